// File: rtl/regwrite_encoder_16x4.sv
// regwrite_encoder_16x4: queues 16 write-request pulses and issues them one at a time as regWrite/writeRegister.
// Define RR_ENCODER_FIXED_PRIO_EN to pin the search start at 0 (lowest pending index always wins).
module regwrite_encoder_16x4 (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] req,
   input  logic        accept,
   output logic        regWrite,
   output logic [3:0]  writeRegister,
   output logic [15:0] pending
);
   logic [15:0] pending_q, pending_d, rot;
   logic [3:0]  ptr_q, ptr_d, idx_q, idx_d, sel, off;
   logic        valid_q, valid_d, load;
   always_comb begin
      // rotate so bit 0 of rot is the search start; lowest set bit is the winner
      rot = 16'({pending_q, pending_q} >> ptr_q);
      off = '0;
      for (int i = 15; i >= 0; i--) off = rot[i] ? 4'(i) : off;
      sel = ptr_q + off;
      load = (|pending_q) && (!valid_q || accept);
      pending_d = (pending_q & ~(load ? 16'd1 << sel : 16'd0)) | req;
      valid_d = load | (valid_q & ~accept);
      idx_d = load ? sel : idx_q;
`ifdef RR_ENCODER_FIXED_PRIO_EN
      ptr_d = 4'd0;
`else
      ptr_d = load ? sel + 4'd1 : ptr_q;
`endif
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
         ptr_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
      end
   end
   assign regWrite      = valid_q;
   assign writeRegister = idx_q;
   assign pending       = pending_q;
endmodule

// File: doc/regwrite_encoder_16x4.md
# regwrite_encoder_16x4

Round-robin request encoder for the register-file write port, the counterpart of the 4-to-16 write-enable decoder. Up to 16 producers raise single-cycle write requests. The block queues them as a pending bitmap and presents one request at a time to the register file as a `regWrite` strobe plus a 4-bit `writeRegister` index. The output uses a valid/accept handshake, so the consumer can stall it.

## Interface
- Parameters: none; geometry is fixed at 16 requesters and a 4-bit index.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; `reset`=0 clears all state immediately.
- `req`  input  16  request pulses; bit i high for one cycle posts a request for register i. Multiple bits per cycle are allowed.
- `accept`  input  1  consumer ready; the transfer completes on an edge where `regWrite`=1 and `accept`=1.
- `regWrite`  output  1  output slot valid.
- `writeRegister`  output  4  index of the request in the output slot.
- `pending`  output  16  registered pending bitmap, for status and verification.

## Operation
- State:
  - `pending[15:0]` bitmap.
  - `ptr[3:0]`, the round-robin search start.
  - Output slot `{regWrite, writeRegister}`.
- Load condition: `load = (|pending) && (!regWrite || accept)`.
- Selection when `load`=1:
  - `sel` is the first set bit of `pending`, scanning upward from `ptr` with wrap-around from 15 to 0.
  - Only the registered `pending` is scanned; same-cycle `req` bits are not considered.
- On an edge with `load`=1:
  - `writeRegister` <= `sel`.
  - `regWrite` <= 1.
  - `ptr` <= `sel`+1, mod 16 (15 wraps to 0).
- On an edge with `regWrite && accept && !load`: `regWrite` <= 0. `writeRegister` holds its last value.
- Pending update on every edge: `pending` <= (`pending` & ~(`load` ? onehot(`sel`) : 0)) | `req`.
  - Set wins: a `req` bit for the index being loaded re-pends it.
  - A `req` bit already pending is merged; no count is kept.
  - A `req` for the index currently in the output slot pends a second service of that index.
- While `regWrite`=1 and `accept`=0, `regWrite` and `writeRegister` hold stable. `pending` may still gain bits.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - `pending`=0, `ptr`=0, `regWrite`=0, `writeRegister`=0.
  - Applies mid-transfer: a stalled output slot is discarded and pending requests are lost.
- Latency with an idle output:
  - `req` sampled at edge E1.
  - The bit appears in `pending` after E1.
  - It is loaded at E2; `regWrite`=1 after E2.
  - Total: 2 cycles from the request edge to a visible strobe.
- Throughput: one transfer per cycle while `accept`=1 and `pending` is nonzero. Back-to-back loads happen on the same edge as the accepting edge.
- `accept` while `regWrite`=0 is ignored.
- Outputs are all registered; there is no combinational path from `req` or `accept` to any output.

## Configuration
- `RR_ENCODER_FIXED_PRIO_EN`
  - Defined: `ptr` is tied to 0, so the lowest pending index always wins. Starvation of high indices is possible and is accepted in this build.
  - Undefined (default): round-robin behaviour as in Operation.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: build `pending`=0x00F0 with `regWrite`=1 and `accept`=0, then drop `reset` mid-cycle. Required: all outputs 0 without waiting for a clock edge. After release with `req`=0, `regWrite` stays 0.
- Single request: `req`=0x0020 for one cycle with `accept`=1. Required: `regWrite`=1 and `writeRegister`=5 for exactly one cycle, two edges after the request. `pending` returns to 0.
- Burst: `req`=0xFFFF for one cycle with `accept`=1. Required: `writeRegister`=0,1,2,…,15 on 16 consecutive cycles, then `regWrite`=0.
- Backpressure: `req`=0x0208 with `accept`=0 for 5 cycles. Required: `writeRegister`=3 held stable with `pending`=0x0200. Then raise `accept`: required `writeRegister`=9 next, then `regWrite`=0.
- Round-robin order: after serving 9 (`ptr`=10), pulse `req`=0x1004. Required order: 12 then 2. With `RR_ENCODER_FIXED_PRIO_EN` defined, the required order is 2 then 12.
- Re-request: index 3 is stalled in the output slot and `req`=0x0008 is pulsed. Required: index 3 is served twice (two accepted transfers with `writeRegister`=3), and `pending` ends at 0.
